pc_next_unit: RTL

Program-counter owner for the single-cycle core: consumes the branch decision (`B_type_jump_flag`) plus jump controls and produces the PC for the next instruction. It holds the architectural PC register, selects among sequential, branch, JAL and JALR targets, and detects misaligned targets, redirecting to a trap vector and holding trap state until software acknowledges it. It sits between the branch/ALU logic and instruction memory.

---
 rtl/pc_next_unit_if.sv | 30 +++
 rtl/pc_next_unit.sv | 76 +++++++
 2 files changed

// File: rtl/pc_next_unit_if.sv
// pc_next_unit_if: control inputs and PC/trap/statistics outputs of the next-PC unit
interface pc_next_unit_if;
  logic B_type;
  logic B_type_jump_flag;
  logic J_type;
  logic jalr;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic stall;
  logic trap_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic redirect;
  logic trap_valid;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic double_fault;
  logic [31:0] br_taken_cnt;
  logic [31:0] br_total_cnt;
  modport master(
    output B_type, B_type_jump_flag, J_type, jalr, imm, rs1_data, stall, trap_ack,
    input pc, pc_plus4, redirect, trap_valid, trap_epc, trap_tval, double_fault,
    input br_taken_cnt, br_total_cnt
  );
  modport slave(
    input B_type, B_type_jump_flag, J_type, jalr, imm, rs1_data, stall, trap_ack,
    output pc, pc_plus4, redirect, trap_valid, trap_epc, trap_tval, double_fault,
    output br_taken_cnt, br_total_cnt
  );
endinterface

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register with branch/JAL/JALR selection, misaligned-target trap and optional branch statistics (BRANCH_STATS_EN)
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input logic clk,
  input logic rst_n,
  pc_next_unit_if.slave bus
);
  typedef enum logic {RUN, TRAP} state_t;
  state_t state, state_next;
  logic [31:0] pc, epc, tval, pc_plus4, jalr_sum, target;
  logic redirect, double_fault, mis, take_trap, first_trap;
  assign pc_plus4 = pc + 32'd4;
  assign jalr_sum = bus.rs1_data + bus.imm;
  assign target = bus.jalr ? {jalr_sum[31:1], 1'b0}
                : (bus.J_type || bus.B_type_jump_flag) ? pc + bus.imm : pc_plus4;
  assign mis = |target[1:0];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_next;
  // a misalignment always lands in TRAP; an acknowledge leaves it only when no new fault occurs
  always_comb
    state_next = take_trap ? TRAP : (state == TRAP && bus.trap_ack) ? RUN : state;
  // trap decode: first fault captures epc/tval, a fault while pending is a double fault
  always_comb begin
    take_trap = !bus.stall && mis;
    first_trap = take_trap && state == RUN;
  end
  // PC, redirect flag and trap capture registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      redirect <= 1'b0;
      epc <= '0;
      tval <= '0;
      double_fault <= 1'b0;
    end else if (bus.stall) begin
      redirect <= 1'b0;
    end else begin
      pc <= mis ? TRAP_PC : target;
      redirect <= mis || target != pc_plus4;
      if (first_trap) begin
        epc <= pc;
        tval <= target;
      end
      if (take_trap && !first_trap) double_fault <= 1'b1;
    end
  assign bus.pc = pc;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.redirect = redirect;
  assign bus.trap_valid = state == TRAP;
  assign bus.trap_epc = epc;
  assign bus.trap_tval = tval;
  assign bus.double_fault = double_fault;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt, total_cnt;
  // saturating branch counters, frozen on stalled cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      taken_cnt <= '0;
      total_cnt <= '0;
    end else if (!bus.stall) begin
      if (bus.B_type && total_cnt != '1) total_cnt <= total_cnt + 32'd1;
      if (bus.B_type && bus.B_type_jump_flag && taken_cnt != '1) taken_cnt <= taken_cnt + 32'd1;
    end
  assign bus.br_taken_cnt = taken_cnt;
  assign bus.br_total_cnt = total_cnt;
`else
  logic unused_b_type;
  assign unused_b_type = bus.B_type;
  assign bus.br_taken_cnt = '0;
  assign bus.br_total_cnt = '0;
`endif
endmodule
